button_arrow_encoder: RTL and testbench
=======================================

Name: button_arrow_encoder

Overview:
- Input-side counterpart of the arrow display path.
- Takes the four raw pushbuttons (Up, Down, Left, Right), then synchronises and debounces each one.
- Groups presses that fall inside a chord window and encodes each group into the same 5-bit arrow code set the display and collision logic use (ARROW_UP=10 … ARROW_NONE=20).
- Feeds the hit-detection logic with one validated arrow event per player gesture, plus per-button press pulses.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronised input must hold a new level before the debounced level changes (5 ms at 100 MHz).
- DEB_BITS, 19: width of each debounce counter.
- CHORD_CYCLES, 2000000: chord collection window in cycles (20 ms).
- CHORD_BITS, 21: width of the chord window counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- Up, input, 1: raw button, asynchronous to clk.
- Down, input, 1: raw button, asynchronous to clk.
- Left, input, 1: raw button, asynchronous to clk.
- Right, input, 1: raw button, asynchronous to clk.
- enable, input, 1: high while the game is in its play state.
- held, output, 4: debounced levels; bit 3=Up, 2=Down, 1=Left, 0=Right.
- press_pulse, output, 4: one-cycle pulse on a debounced rising edge, same bit order as held.
- arrow_code, output, 5: encoded gesture; holds its value between events.
- arrow_valid, output, 1: one-cycle strobe; arrow_code is valid in that cycle.
- chord_err, output, 1: one-cycle strobe, coincident with arrow_valid, when 3 or 4 buttons were pressed in the window.

Behaviour:
- Reset (asynchronous, any time including mid-chord) clears everything immediately:
  - synchronisers, debounce counters, held, press_pulse, mask, window counter, arrow_valid and chord_err go to 0;
  - arrow_code goes to 20 (ARROW_NONE);
  - FSM goes to IDLE.
- Synchroniser: 2-FF chain per button.
- Debounce, per button:
  - If the synchronised level equals held, the counter is cleared.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, held takes the new level and the counter clears.
  - A raw level that is stable from edge t updates held at t+DEBOUNCE_CYCLES+2.
  - Any bounce back to the held level restarts the count.
- press_pulse[i] is registered and high for exactly the one cycle after held[i] rises 0→1. Releases produce no pulse.
- Debouncers run regardless of enable.
- FSM states are IDLE, COLLECT and EMIT:
  - IDLE: if enable and press_pulse≠0, go to COLLECT with mask=press_pulse and count=0.
  - COLLECT: each cycle mask|=press_pulse and count increments. When count=CHORD_CYCLES-1, go to EMIT.
  - EMIT: drive arrow_valid=1 for this single cycle and update arrow_code from mask.
  - Exit from EMIT: if enable and press_pulse≠0 in the EMIT cycle, go to COLLECT with mask=press_pulse and count=0; otherwise go to IDLE with mask=0.
  - A press in the EMIT cycle is never dropped or merged into the emitted chord.
- enable low in COLLECT or EMIT forces IDLE on the next edge:
  - mask is cleared;
  - no arrow_valid or chord_err is issued;
  - arrow_code is unchanged.
- Latency: arrow_valid asserts CHORD_CYCLES+1 cycles after the press_pulse that opened the window.
- Encoding of mask [U,D,L,R]:

  | mask | arrow_code |
  |---|---|
  | 1000 | 10 |
  | 0100 | 11 |
  | 0010 | 12 |
  | 0001 | 13 |
  | 1100 | 14 |
  | 1010 | 15 |
  | 1001 | 16 |
  | 0110 | 17 |
  | 0101 | 18 |
  | 0011 | 19 |
  | 3 or 4 bits set | 20, with chord_err=1 |

- A button pressed twice within one window counts once: mask is an OR.
- The window is fixed from the first press and is not extended by later presses.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, CHORD_CYCLES=8, enable=1 unless stated.
1. Up rises cleanly at cycle 0 → held[3]=1 at cycle 6 and press_pulse[3] high only at cycle 7; arrow_valid high only at cycle 16 with arrow_code=10 and chord_err=0.
2. Up toggles every 2 cycles for 20 cycles, then stays high → held[3] rises once, exactly 6 cycles after the final edge; exactly one press_pulse and one arrow_valid (code 10); no events during the bounce.
3. Up at cycle 0, then Left at cycle 3, both held → one arrow_valid with code 15, 9 cycles after Up's press_pulse; no second valid.
4. Down, Left and Right rising within 5 cycles → one arrow_valid with code 20 and chord_err=1 in the same cycle.
5. Right pressed, then enable dropped 3 cycles into COLLECT → no arrow_valid or chord_err; arrow_code keeps its previous value; FSM in IDLE; held[0] still reaches 1.
6. reset pulsed mid-COLLECT after a completed code-14 event → arrow_code=20, held=0 and arrow_valid=0 asynchronously, with no clock edge; after release, a fresh Up press yields code 10 at the normal latency.

Source files
------------

// File: rtl/button_arrow_encoder.sv
// Synchronises and debounces four pushbuttons, then groups presses inside a fixed chord window into one arrow event.
// arrow_valid fires CHORD_CYCLES+1 cycles after the opening press pulse; there is no backpressure.
module button_arrow_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_BITS        = 19,
  parameter int CHORD_CYCLES    = 2000000,
  parameter int CHORD_BITS      = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       enable,
  output logic [3:0] held,
  output logic [3:0] press_pulse,
  output logic [4:0] arrow_code,
  output logic       arrow_valid,
  output logic       chord_err
);

  localparam logic [4:0] ARROW_UP       = 5'd10;
  localparam logic [4:0] ARROW_DOWN     = 5'd11;
  localparam logic [4:0] ARROW_LEFT     = 5'd12;
  localparam logic [4:0] ARROW_RIGHT    = 5'd13;
  localparam logic [4:0] ARROW_UP_DOWN  = 5'd14;
  localparam logic [4:0] ARROW_UP_LEFT  = 5'd15;
  localparam logic [4:0] ARROW_UP_RIGHT = 5'd16;
  localparam logic [4:0] ARROW_DN_LEFT  = 5'd17;
  localparam logic [4:0] ARROW_DN_RIGHT = 5'd18;
  localparam logic [4:0] ARROW_LR       = 5'd19;
  localparam logic [4:0] ARROW_NONE     = 5'd20;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam logic [DEB_BITS-1:0]   DEB_LAST   = DEB_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHORD_BITS-1:0] CHORD_LAST = CHORD_BITS'(CHORD_CYCLES - 1);

  logic [3:0]                raw;
  logic [3:0]                sync1_q, sync2_q;
  logic [3:0]                held_q, held_d, held_dly_q, pulse_q;
  logic [3:0][DEB_BITS-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]                state_q, state_d;
  logic [3:0]                mask_q, mask_d;
  logic [CHORD_BITS-1:0]     win_cnt_q, win_cnt_d;
  logic [4:0]                code_q, code_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  assign raw = {Up, Down, Left, Right};

  function automatic logic [5:0] encode(input logic [3:0] m);
    logic [5:0] r;
    case (m)
      4'b1000: r = {1'b0, ARROW_UP};
      4'b0100: r = {1'b0, ARROW_DOWN};
      4'b0010: r = {1'b0, ARROW_LEFT};
      4'b0001: r = {1'b0, ARROW_RIGHT};
      4'b1100: r = {1'b0, ARROW_UP_DOWN};
      4'b1010: r = {1'b0, ARROW_UP_LEFT};
      4'b1001: r = {1'b0, ARROW_UP_RIGHT};
      4'b0110: r = {1'b0, ARROW_DN_LEFT};
      4'b0101: r = {1'b0, ARROW_DN_RIGHT};
      4'b0011: r = {1'b0, ARROW_LR};
      4'b0000: r = {1'b0, ARROW_NONE};
      default: r = {1'b1, ARROW_NONE};
    endcase
    return r;
  endfunction

  // Any sample matching the held level restarts that button's count.
  always_comb begin
    held_d    = held_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != held_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          held_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    win_cnt_d = win_cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (pulse_q != 4'b0000)) begin
          state_d   = S_COLLECT;
          mask_d    = pulse_q;
          win_cnt_d = '0;
        end
      end
      S_COLLECT: begin
        if (!enable) begin
          state_d   = S_IDLE;
          mask_d    = '0;
          win_cnt_d = '0;
        end else begin
          mask_d = mask_q | pulse_q;
          if (win_cnt_q == CHORD_LAST) begin
            state_d           = S_EMIT;
            win_cnt_d         = '0;
            valid_d           = 1'b1;
            {err_d, code_d}   = encode(mask_d);
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        // A press landing in the emit cycle opens the next window rather than joining this one.
        if (enable && (pulse_q != 4'b0000)) begin
          state_d   = S_COLLECT;
          mask_d    = pulse_q;
          win_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
          mask_d  = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mask_d    = '0;
        win_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      held_q     <= '0;
      held_dly_q <= '0;
      pulse_q    <= '0;
      deb_cnt_q  <= '0;
      state_q    <= S_IDLE;
      mask_q     <= '0;
      win_cnt_q  <= '0;
      code_q     <= ARROW_NONE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      held_q     <= held_d;
      held_dly_q <= held_q;
      pulse_q    <= held_q & ~held_dly_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      win_cnt_q  <= win_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign held        = held_q;
  assign press_pulse = pulse_q;
  assign arrow_code  = code_q;
  assign arrow_valid = valid_q;
  assign chord_err   = err_q;

endmodule

// File: tb/tb_button_arrow_encoder.sv
// Randomised and directed bench for button_arrow_encoder with a window-level reference model and event scoreboard.
module tb_button_arrow_encoder;
  localparam int D = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] held, press_pulse;
  logic [4:0] arrow_code;
  logic       arrow_valid, chord_err;

  button_arrow_encoder #(
    .DEBOUNCE_CYCLES(D), .DEB_BITS(3), .CHORD_CYCLES(C), .CHORD_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .enable(enable), .held(held), .press_pulse(press_pulse), .arrow_code(arrow_code),
    .arrow_valid(arrow_valid), .chord_err(chord_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [4:0] code; logic err; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [3:0] m_held, m_held_old, m_pulse;
  logic [4:0] m_code;
  logic [3:0] hist[$];
  bit         win_open;
  int         wstart;
  logic [3:0] wmask;

  // observations
  int         n_valid = 0;
  int         n_pulse[4] = '{0, 0, 0, 0};
  int         rise_cyc[4] = '{0, 0, 0, 0};
  int         pulse_cyc[4] = '{0, 0, 0, 0};
  int         last_valid_cyc = 0;
  logic [4:0] last_code = 5'd0;
  logic       last_err = 1'b0;
  logic [3:0] prev_held = 4'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit for button index b (0=Up .. 3=Right); singles come first, then pairs in U,D,L,R order.
  function automatic logic [5:0] ref_encode(input logic [3:0] m);
    int code;
    if ($countones(m) >= 3) return {1'b1, 5'd20};
    code = 10;
    for (int b = 0; b < 4; b++) begin
      if (m == (4'b1000 >> b)) return {1'b0, 5'(code)};
      code++;
    end
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++) begin
        if (m == ((4'b1000 >> a) | (4'b1000 >> b))) return {1'b0, 5'(code)};
        code++;
      end
    return {1'b0, 5'd20};
  endfunction

  task automatic model_reset();
    m_held = '0; m_held_old = '0; m_pulse = '0; m_code = 5'd20;
    win_open = 0; wstart = 0; wmask = '0;
    hist.delete();
    repeat (D + 1) hist.push_back(4'b0);
  endtask

  task automatic model_step(input logic en, input logic [3:0] r);
    logic [5:0] enc;
    bit         all_diff;
    // window bookkeeping uses what was visible during the previous cycle
    if (win_open) begin
      if (!en) win_open = 0;
      else begin
        wmask |= m_pulse;
        if (cyc - 1 == wstart + C) begin
          enc = ref_encode(wmask);
          m_code = enc[4:0];
          exp_q.push_back('{cyc, enc[4:0], enc[5]});
          win_open = 0;
        end
      end
    end else if (en && m_pulse != 4'b0) begin
      win_open = 1; wstart = cyc - 1; wmask = m_pulse;
    end
    m_pulse = m_held & ~m_held_old;
    m_held_old = m_held;
    // a level change needs D consecutive differing samples, seen two flops late
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      for (int j = 0; j < D; j++) if (hist[j][i] == m_held[i]) all_diff = 0;
      if (all_diff) m_held[i] = ~m_held[i];
    end
    hist.push_back(r);
    void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) model_reset();
      else model_step(enable, {Up, Down, Left, Right});
    end
  end

  initial begin
    ev_t ev;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("held", held, m_held);
      check("press_pulse", press_pulse, m_pulse);
      check("arrow_code", arrow_code, m_code);
      for (int i = 0; i < 4; i++) begin
        if (held[i] && !prev_held[i]) rise_cyc[i] = cyc;
        if (press_pulse[i]) begin n_pulse[i]++; pulse_cyc[i] = cyc; end
      end
      prev_held = held;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        check("missed_event_cycle", cyc, ev.cyc);
      end
      if (arrow_valid) begin
        n_valid++; last_valid_cyc = cyc; last_code = arrow_code; last_err = chord_err;
        if (exp_q.size() == 0) check("unexpected_valid_queue", 0, 1);
        else begin
          ev = exp_q.pop_front();
          check("valid_cycle", cyc, ev.cyc);
          check("valid_code", arrow_code, ev.code);
          check("valid_err", chord_err, ev.err);
        end
      end else begin
        check("err_without_valid", chord_err, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int b);
    int t;
    t = 0;
    while (!press_pulse[b] && t < 60) begin @(negedge clk); t++; end
    check("wait_pulse_timeout", int'(press_pulse[b]), 1);
  endtask

  initial begin
    int e, v0, p0;
    logic [4:0] code_before;
    logic [3:0] target;
    idle(3);
    #2 reset = 1'b0;
    idle(2);
    check("reset_code", arrow_code, 20);
    check("reset_held", held, 0);

    // clean single press
    @(negedge clk); e = cyc; v0 = n_valid; Up = 1'b1;
    idle(22);
    check("t1_held_rise", rise_cyc[3], e + 6);
    check("t1_pulse", pulse_cyc[3], e + 7);
    check("t1_valid_cyc", last_valid_cyc, e + 16);
    check("t1_code", last_code, 10);
    check("t1_nvalid", n_valid - v0, 1);
    Up = 1'b0; idle(12);

    // bouncing press
    v0 = n_valid; p0 = n_pulse[3];
    for (int i = 0; i < 10; i++) begin Up = ~Up; idle(2); end
    e = cyc; Up = 1'b1;
    idle(26);
    check("t2_held_rise", rise_cyc[3], e + 6);
    check("t2_npulse", n_pulse[3] - p0, 1);
    check("t2_nvalid", n_valid - v0, 1);
    check("t2_code", last_code, 10);
    Up = 1'b0; idle(12);

    // two-button chord
    v0 = n_valid;
    Up = 1'b1; idle(3); Left = 1'b1;
    idle(28);
    check("t3_latency", last_valid_cyc - pulse_cyc[3], 9);
    check("t3_code", last_code, 15);
    check("t3_nvalid", n_valid - v0, 1);
    Up = 1'b0; Left = 1'b0; idle(12);

    // three-button chord
    v0 = n_valid;
    Down = 1'b1; idle(2); Left = 1'b1; idle(2); Right = 1'b1;
    idle(26);
    check("t4_code", last_code, 20);
    check("t4_err", last_err, 1);
    check("t4_nvalid", n_valid - v0, 1);
    Down = 1'b0; Left = 1'b0; Right = 1'b0; idle(12);

    // enable dropped mid-window
    v0 = n_valid; code_before = arrow_code;
    Right = 1'b1;
    wait_pulse(0);
    idle(3); enable = 1'b0;
    idle(18);
    check("t5_nvalid", n_valid - v0, 0);
    check("t5_code_kept", arrow_code, code_before);
    check("t5_held", held[0], 1);
    enable = 1'b1; Right = 1'b0; idle(12);

    // async reset during a window
    Up = 1'b1; Down = 1'b1; idle(26);
    check("t6_code14", last_code, 14);
    Up = 1'b0; Down = 1'b0; idle(12);
    Left = 1'b1;
    wait_pulse(1);
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("t6_async_code", arrow_code, 20);
    check("t6_async_held", held, 0);
    check("t6_async_valid", arrow_valid, 0);
    Left = 1'b0;
    idle(2);
    #2 reset = 1'b0;
    @(negedge clk); e = cyc; v0 = n_valid; Up = 1'b1;
    idle(22);
    check("t6_valid_cyc", last_valid_cyc, e + 16);
    check("t6_code", last_code, 10);
    check("t6_nvalid", n_valid - v0, 1);
    Up = 1'b0; idle(12);

    // random gestures with bounce and occasional enable drops
    for (int it = 0; it < 80; it++) begin
      target = 4'($urandom_range(0, 15));
      for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
        {Up, Down, Left, Right} = 4'($urandom_range(0, 15));
        idle(1);
      end
      {Up, Down, Left, Right} = target;
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 12));
        enable = 1'b0;
        idle($urandom_range(1, 6));
        enable = 1'b1;
      end
      idle($urandom_range(1, 30));
    end
    {Up, Down, Left, Right} = 4'b0;
    idle(40);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
